gost89_gamma_engine: RTL and testbench

GOST89_GAMMA_ENGINE -- requirements
Module: gost89_gamma_engine

---
 rtl/gost89_pkg.sv | 25 ++
 rtl/gost89_ecb_encrypt.sv | 59 +++++
 rtl/gost89_gamma_engine.sv | 167 ++++++++++++++++
 tb/tb_gost89_gamma_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gost89_pkg.sv
// Shared encodings and constants for the GOST 28147-89 gamma engine.
package gost89_pkg;

   typedef enum logic [1:0] {
      MODE_CFB_ENC = 2'b00,
      MODE_CFB_DEC = 2'b01,
      MODE_OFB     = 2'b10,
      MODE_CTR     = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GEN   = 2'b01,
      AVAIL = 2'b10,
      HOLD  = 2'b11
   } state_t;

   localparam logic [31:0] C1 = 32'h01010104;
   localparam logic [31:0] C2 = 32'h01010101;

   function automatic bit seg_w_legal(input int w);
      return (w == 8) || (w == 16) || (w == 32) || (w == 64);
   endfunction

endpackage

// File: rtl/gost89_ecb_encrypt.sv
// Iterative GOST 28147-89 block encryption: one Feistel round per clock, 32 rounds.
module gost89_ecb_encrypt
   import gost89_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [63:0]  block_in,
   input  logic [255:0] key,
   input  logic [511:0] sbox,
   output logic [63:0]  block_out,
   output logic         done
);

   logic [31:0] a, b, sum, subst, f_out;
   logic [4:0]  round;
   logic [2:0]  key_sel;
   logic        running;

   // Key order K0..K7 three times, then K7..K0 for the last eight rounds.
   always_comb begin
      key_sel = (round[4:3] == 2'b11) ? ~round[2:0] : round[2:0];
      sum     = a + key[{key_sel, 5'd0} +: 32];
      subst   = '0;
      for (int j = 0; j < 8; j++) begin
         subst[4*j +: 4] = sbox[{j[2:0], sum[4*j +: 4], 2'b00} +: 4];
      end
      f_out = {subst[20:0], subst[31:21]} ^ b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a         <= '0;
         b         <= '0;
         round     <= '0;
         running   <= 1'b0;
         done      <= 1'b0;
         block_out <= '0;
      end else begin
         done <= 1'b0;
         if (load) begin
            a       <= block_in[31:0];
            b       <= block_in[63:32];
            round   <= '0;
            running <= 1'b1;
         end else if (running) begin
            a     <= f_out;
            b     <= a;
            round <= round + 5'd1;
            if (round == 5'd31) begin
               running   <= 1'b0;
               done      <= 1'b1;
               block_out <= {f_out, a};
            end
         end
      end
   end

endmodule

// File: rtl/gost89_gamma_engine.sv
// GOST 28147-89 gamma engine (CFB / OFB, plus CTR when GOST89_CTR_EN is defined;
// without it mode 11 runs as OFB). All encryptions share one iterative ECB core.
module gost89_gamma_engine
   import gost89_pkg::*;
#(
   parameter int SEG_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             iv_load,
   input  logic [63:0]      iv,
   input  logic [511:0]     sbox,
   input  logic [255:0]     key,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEG_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEG_W-1:0] out_data,
   output logic             busy
);

   if (!seg_w_legal(SEG_W)) begin : g_bad_seg_w
      $error("gost89_gamma_engine: SEG_W must be 8, 16, 32 or 64");
   end

   localparam int SEGS = 64 / SEG_W;

   state_t           state, next_state;
   mode_t            mode_q, mode_eff;
   logic [63:0]      r, k, core_in, core_out;
   logic [SEG_W-1:0] out_q, seg_res, seg_fb;
   logic [3:0]       seg_idx;
   logic             gen_first, core_load, core_reset, core_done, ctr_pending, is_cfb;

`ifdef GOST89_CTR_EN
   logic [63:0] n;
   logic        ctr_init;

   // High half adds modulo 2^32-1 with end-around carry, so 0xFFFFFFFF survives.
   function automatic logic [63:0] ctr_advance(input logic [63:0] v);
      logic [32:0] hi;
      hi = {1'b0, v[63:32]} + {1'b0, C1};
      return {hi[31:0] + {31'd0, hi[32]}, v[31:0] + C2};
   endfunction

   assign ctr_pending = ctr_init;
`else
   assign ctr_pending = 1'b0;
`endif

   always_comb begin
      mode_eff = mode_t'(mode);
`ifndef GOST89_CTR_EN
      if (mode_t'(mode) == MODE_CTR) mode_eff = MODE_OFB;
`endif
   end

   assign is_cfb     = (mode_q == MODE_CFB_ENC) || (mode_q == MODE_CFB_DEC);
   assign seg_res    = in_data ^ k[63 -: SEG_W];
   assign seg_fb     = (mode_q == MODE_CFB_DEC) ? in_data : seg_res;
   assign core_reset = reset | iv_load;

   gost89_ecb_encrypt u_core (
      .clk       (clk),
      .reset     (core_reset),
      .load      (core_load),
      .block_in  (core_in),
      .key       (key),
      .sbox      (sbox),
      .block_out (core_out),
      .done      (core_done)
   );

   // The core is started only in the first cycle after entering GEN.
   always_comb begin
      next_state = state;
      core_load  = 1'b0;
      core_in    = r;
`ifdef GOST89_CTR_EN
      if (mode_q == MODE_CTR && !ctr_init) core_in = ctr_advance(n);
`endif
      case (state)
         GEN: begin
            if (gen_first) core_load = 1'b1;
            else if (core_done && !ctr_pending) next_state = AVAIL;
         end
         AVAIL: if (in_valid) next_state = HOLD;
         HOLD: begin
            if (out_ready) next_state = (!is_cfb && seg_idx < 4'(SEGS)) ? AVAIL : GEN;
         end
         default: next_state = state;
      endcase
      if (iv_load) next_state = GEN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mode_q    <= MODE_CFB_ENC;
         r         <= '0;
         k         <= '0;
         out_q     <= '0;
         seg_idx   <= '0;
         gen_first <= 1'b0;
`ifdef GOST89_CTR_EN
         n         <= '0;
         ctr_init  <= 1'b0;
`endif
      end else begin
         state     <= next_state;
         gen_first <= 1'b0;
         if (iv_load) begin
            mode_q    <= mode_eff;
            r         <= iv;
            k         <= '0;
            out_q     <= '0;
            seg_idx   <= '0;
            gen_first <= 1'b1;
`ifdef GOST89_CTR_EN
            ctr_init  <= (mode_eff == MODE_CTR);
`endif
         end else begin
            case (state)
               GEN: begin
                  if (gen_first) begin
`ifdef GOST89_CTR_EN
                     if (mode_q == MODE_CTR && !ctr_init) n <= core_in;
`endif
                  end else if (core_done) begin
                     k       <= core_out;
                     seg_idx <= '0;
                     if (mode_q == MODE_OFB) r <= core_out;
`ifdef GOST89_CTR_EN
                     // First CTR run only produced E(iv); restart for the real block.
                     if (ctr_init) begin
                        n         <= core_out;
                        ctr_init  <= 1'b0;
                        gen_first <= 1'b1;
                     end
`endif
                  end
               end
               AVAIL: begin
                  if (in_valid) begin
                     out_q   <= seg_res;
                     k       <= k << SEG_W;
                     seg_idx <= seg_idx + 4'd1;
                     if (is_cfb) r <= (r << SEG_W) | 64'(seg_fb);
                  end
               end
               HOLD: begin
                  if (out_ready && next_state == GEN) gen_first <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready  = (state == AVAIL);
   assign out_valid = (state == HOLD);
   assign busy      = (state == GEN);
   assign out_data  = out_q;

endmodule

// File: tb/tb_gost89_gamma_engine.sv
// Self-checking bench for gost89_gamma_engine: SEG_W=64 and SEG_W=8 instances against a
// software GOST 28147-89 gamma model.
module tb_gost89_gamma_engine;
   import gost89_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, iv_load, in_valid, out_ready, sel;
   logic [1:0]   mode;
   logic [63:0]  iv, in_data;
   logic [511:0] sbox;
   logic [255:0] key;

   logic        iv_load64, iv_load8, in_valid64, in_valid8;
   logic        in_ready64, out_valid64, busy64, in_ready8, out_valid8, busy8;
   logic [63:0] out_data64;
   logic [7:0]  out_data8;
   logic        cur_in_ready, cur_out_valid, cur_busy;
   logic [63:0] cur_out_data;

   assign iv_load64     = iv_load & ~sel;
   assign iv_load8      = iv_load & sel;
   assign in_valid64    = in_valid & ~sel;
   assign in_valid8     = in_valid & sel;
   assign cur_in_ready  = sel ? in_ready8 : in_ready64;
   assign cur_out_valid = sel ? out_valid8 : out_valid64;
   assign cur_busy      = sel ? busy8 : busy64;
   assign cur_out_data  = sel ? {56'd0, out_data8} : out_data64;

   gost89_gamma_engine #(.SEG_W(64)) dut64 (
      .clk(clk), .reset(reset), .mode(mode), .iv_load(iv_load64), .iv(iv),
      .sbox(sbox), .key(key), .in_valid(in_valid64), .in_ready(in_ready64),
      .in_data(in_data), .out_valid(out_valid64), .out_ready(out_ready),
      .out_data(out_data64), .busy(busy64)
   );

   gost89_gamma_engine #(.SEG_W(8)) dut8 (
      .clk(clk), .reset(reset), .mode(mode), .iv_load(iv_load8), .iv(iv),
      .sbox(sbox), .key(key), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data[7:0]), .out_valid(out_valid8), .out_ready(out_ready),
      .out_data(out_data8), .busy(busy8)
   );

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Counts busy rising edges of the 8-bit instance (one per block encryption in CFB).
   int   rises = 0;
   logic busy8_q = 1'b0;
   always @(posedge clk) begin
      busy8_q <= busy8;
      if (busy8 && !busy8_q) rises <= rises + 1;
   end

   // ---------------- software model ----------------
   function automatic logic [31:0] gost_f(input logic [31:0] x);
      logic [31:0] s;
      for (int j = 0; j < 8; j++) s[4*j +: 4] = sbox[64*j + 4*int'(x[4*j +: 4]) +: 4];
      return {s[20:0], s[31:21]};
   endfunction

   function automatic int key_index(input int i);
      return (i < 24) ? (i % 8) : (31 - i);
   endfunction

   function automatic logic [63:0] gost_enc(input logic [63:0] blk);
      logic [31:0] a, b, t;
      a = blk[31:0];
      b = blk[63:32];
      for (int i = 0; i < 32; i++) begin
         t = gost_f(a + key[32*key_index(i) +: 32]) ^ b;
         b = a;
         a = t;
      end
      return {a, b};
   endfunction

   function automatic logic [63:0] gost_dec(input logic [63:0] blk);
      logic [31:0] a, b, pa;
      a = blk[63:32];
      b = blk[31:0];
      for (int i = 31; i >= 0; i--) begin
         pa = b;
         b  = a ^ gost_f(b + key[32*key_index(i) +: 32]);
         a  = pa;
      end
      return {b, a};
   endfunction

`ifdef GOST89_CTR_EN
   function automatic logic [63:0] ctr_adv(input logic [63:0] v);
      logic [63:0] hi;
      logic [31:0] lo;
      lo = v[31:0] + 32'h01010101;
      hi = 64'(v[63:32]) + 64'h01010104;
      if (hi > 64'hFFFF_FFFF) hi = hi - 64'hFFFF_FFFF;
      return {hi[31:0], lo};
   endfunction
`endif

   int          w = 64;
   logic [1:0]  m_mode;
   logic [63:0] m_r, m_n;
   logic [63:0] ks_q[$];
   logic [63:0] last_out;

   task automatic model_begin(input logic [1:0] md, input logic [63:0] v);
      m_mode = md;
      m_r    = v;
      m_n    = '0;
      ks_q.delete();
`ifdef GOST89_CTR_EN
      if (md == 2'b11) m_n = gost_enc(v);
`else
      if (md == 2'b11) m_mode = 2'b10;
`endif
   endtask

   task automatic model_next(input logic [63:0] din, output logic [63:0] dout);
      logic [63:0] mask, blk, c;
      mask = (64'd1 << w) - 64'd1;
      if (!m_mode[1]) begin
         blk  = gost_enc(m_r);
         dout = (din ^ (blk >> (64 - w))) & mask;
         c    = m_mode[0] ? (din & mask) : dout;
         m_r  = (m_r << w) | c;
      end else begin
         if (ks_q.size() == 0) begin
            if (m_mode == 2'b10) begin
               m_r = gost_enc(m_r);
               blk = m_r;
            end else begin
`ifdef GOST89_CTR_EN
               m_n = ctr_adv(m_n);
`endif
               blk = gost_enc(m_n);
            end
            for (int i = 0; i < 64 / w; i++) ks_q.push_back((blk >> (64 - w * (i + 1))) & mask);
         end
         dout = (din ^ ks_q.pop_front()) & mask;
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_message(input logic s, input logic [1:0] md, input logic [63:0] v);
      @(negedge clk);
      sel     = s;
      w       = s ? 8 : 64;
      mode    = md;
      iv      = v;
      iv_load = 1'b1;
      @(negedge clk);
      iv_load = 1'b0;
      mode    = $urandom_range(0, 3);
      model_begin(md, v);
      checkOutput("busy_after_load", 64'(cur_busy), 64'd1);
      checkOutput("out_valid_after_load", 64'(cur_out_valid), 64'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cur_in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready_wait", 64'(cur_in_ready), 64'd1);
   endtask

   task automatic applyStimulus(input logic [63:0] din, input int hold);
      logic [63:0] exp;
      wait_ready();
      model_next(din, exp);
      in_data   = din;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("out_valid", 64'(cur_out_valid), 64'd1);
      checkOutput("out_data", cur_out_data, exp);
      last_out = cur_out_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 64'(cur_out_valid), 64'd1);
         checkOutput("hold_data", cur_out_data, exp);
         checkOutput("hold_in_ready", 64'(cur_in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic enter_hold(input logic [63:0] din);
      wait_ready();
      in_data   = din;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("enter_hold_valid", 64'(cur_out_valid), 64'd1);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   logic [7:0] pt[16];
   logic [7:0] ct[16];

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      logic [63:0] din, civ;
      reset = 1'b1; iv_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      mode = 2'b00; iv = '0; in_data = '0; sel = 1'b0;
      for (int i = 0; i < 16; i++) sbox[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
      repeat (3) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         checkOutput("rst_busy", 64'(cur_busy), 64'd0);
         checkOutput("rst_in_ready", 64'(cur_in_ready), 64'd0);
         checkOutput("rst_out_valid", 64'(cur_out_valid), 64'd0);
         checkOutput("rst_out_data", cur_out_data, 64'd0);
      end
      reset = 1'b0;

      // OFB, 64-bit segments, fixed iv, two blocks
      start_message(1'b0, 2'b10, 64'h0123456789ABCDEF);
      repeat (2) applyStimulus(rnd64(), 0);

      // OFB, 8-bit segments across a block boundary with a long output stall
      start_message(1'b1, 2'b10, rnd64());
      for (int i = 0; i < 10; i++) applyStimulus(rnd64(), (i == 2) ? 10 : 0);

      // CFB round trip, 8-bit segments, one encryption per segment
      civ = rnd64();
      do_reset();
      base = rises;
      start_message(1'b1, 2'b00, civ);
      for (int i = 0; i < 16; i++) begin
         pt[i] = 8'($urandom);
         applyStimulus({56'd0, pt[i]}, 0);
         ct[i] = last_out[7:0];
      end
      checkOutput("cfb_enc_runs", 64'(rises - base), 64'd16);
      do_reset();
      base = rises;
      start_message(1'b1, 2'b01, civ);
      for (int i = 0; i < 16; i++) begin
         applyStimulus({56'd0, ct[i]}, 0);
         checkOutput("cfb_plain_restored", last_out, {56'd0, pt[i]});
      end
      checkOutput("cfb_dec_runs", 64'(rises - base), 64'd16);

      // CFB with 64-bit segments
      start_message(1'b0, 2'b00, rnd64());
      repeat (3) applyStimulus(rnd64(), 0);
      start_message(1'b0, 2'b01, rnd64());
      repeat (2) applyStimulus(rnd64(), 0);

`ifdef GOST89_CTR_EN
      // E(iv) = FFFFFFFE_FFFFFFFF gives first counter {01010103, 01010100}
      start_message(1'b0, 2'b11, gost_dec(64'hFFFFFFFE_FFFFFFFF));
      din = rnd64();
      applyStimulus(din, 0);
      checkOutput("ctr_first_counter", last_out, din ^ gost_enc(64'h01010103_01010100));
      applyStimulus(rnd64(), 0);
      // high half FEFEFEFB advances to FFFFFFFF, not 0
      start_message(1'b0, 2'b11, gost_dec(64'hFEFEFEFB_89ABCDEF));
      din = rnd64();
      applyStimulus(din, 0);
      checkOutput("ctr_n4_all_ones", last_out, din ^ gost_enc({32'hFFFFFFFF, 32'h89ABCDEF + 32'h01010101}));
      start_message(1'b1, 2'b11, rnd64());
      for (int i = 0; i < 12; i++) applyStimulus(rnd64(), 0);
`else
      // Without CTR support mode 11 must reproduce OFB
      civ = rnd64();
      start_message(1'b1, 2'b11, civ);
      for (int i = 0; i < 10; i++) applyStimulus(rnd64(), 0);
      start_message(1'b0, 2'b11, civ);
      repeat (2) applyStimulus(rnd64(), 0);
`endif

      // in_valid ignored during GEN, then iv_load mid-GEN restarts the message
      start_message(1'b0, 2'b10, rnd64());
      repeat (5) @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("gen_ignore_valid", 64'(cur_out_valid), 64'd0);
      checkOutput("gen_still_busy", 64'(cur_busy), 64'd1);
      start_message(1'b0, 2'b00, rnd64());
      repeat (3) applyStimulus(rnd64(), 0);

      // iv_load while output is held drops it
      start_message(1'b1, 2'b10, rnd64());
      enter_hold(rnd64());
      start_message(1'b1, 2'b10, rnd64());
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) applyStimulus(rnd64(), 0);

      // reset while output is held
      start_message(1'b0, 2'b10, rnd64());
      enter_hold(rnd64());
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      checkOutput("hold_rst_out_valid", 64'(cur_out_valid), 64'd0);
      checkOutput("hold_rst_out_data", cur_out_data, 64'd0);
      checkOutput("hold_rst_busy", 64'(cur_busy), 64'd0);
      checkOutput("hold_rst_in_ready", 64'(cur_in_ready), 64'd0);
      start_message(1'b0, 2'b10, rnd64());
      repeat (2) applyStimulus(rnd64(), 0);

      // reset mid-encryption, then a fresh message
      start_message(1'b1, 2'b00, rnd64());
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("gen_rst_busy", 64'(cur_busy), 64'd0);
      repeat (40) @(negedge clk);
      checkOutput("gen_rst_stays_idle", 64'(cur_in_ready), 64'd0);
      start_message(1'b1, 2'b00, rnd64());
      repeat (4) applyStimulus(rnd64(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
